// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-target block.
package i2c_pkg;

  // Default 7-bit target address (0xD4 on the wire for a write).
  localparam logic [6:0] I2C_ADDRESS_DEF = 7'h6A;

  // Value of the R/W bit that selects a read burst.
  localparam logic I2C_RW_READ = 1'b1;

  // Protocol FSM states, 4-bit encoding.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and produces
// one-clock event pulses for SCL edges and START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] metastability stage, [1] synced value, [2] previous synced value
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // Shift the raw lines through the synchronizer/history chain.
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda       = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // SDA may only move while SCL is high for a bus condition; SCL must be
  // high both before and after so an SCL edge never masquerades as one.
  assign start_det =  scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a register pointer: write bursts become one-clock
// strobes to an external store, read bursts stream from a synchronous
// store with one clock of read latency.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = I2C_ADDRESS_DEF,
  parameter int         PTR_W       = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SCL,
  inout  wire              SDA,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clock),
    .rst_n     (reset),
    .scl_in    (SCL),
    .sda_in    (SDA),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;      // bits transferred in current byte
  logic [7:0]       sr_q, sr_d;        // shift register (rx and tx)
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;        // 1 = pull SDA low
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  // Next-state logic: bus conditions override everything, then SCL edges
  // advance the byte/ACK sequencing of the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so pointer-write-then-read works.
      state_d = ST_ADDR;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: ;

        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (state_q == ST_WDATA && cnt_q == 4'd7) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = {sr_q[6:0], sda_s};
              ptr_d     = ptr_q + 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == ST_ADDR) begin
              if (sr_q[7:1] == I2C_ADDRESS) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = sr_q[PTR_W-1:0];
              state_d = ST_PTR_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = ST_WDATA_ACK;
              oe_d    = 1'b1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (sr_q[0] == I2C_RW_READ) begin
              // Store output has been stable since the pointer last moved.
              state_d = ST_RDATA;
              sr_d    = rd_data;
              oe_d    = ~rd_data[7];
            end else begin
              state_d = ST_PTR;
              oe_d    = 1'b0;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = ST_WDATA;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
          end
        end

        ST_RDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_RDATA_ACK;
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 1'b1;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end

        ST_RDATA_ACK: begin
          // A NACK ends the read at the rising edge; only an ACK reaches the fall.
          if (scl_rise && sda_s) begin
            state_d = ST_WAIT_STOP;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d = ST_RDATA;
            sr_d    = rd_data;
            oe_d    = ~rd_data[7];
            cnt_d   = 4'd0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 8'd0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign SDA     = oe_q ? 1'b0 : 1'bz;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master, register store, and a pointer/memory model.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic m_oe  = 1'b0;
  wire  sda_bus;
  logic       wr_en, busy;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clock = ~clock;

  i2c_slave_regs dut (
    .clock   (clock),
    .reset   (rst_n),
    .SCL     (scl),
    .SDA     (sda_bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // External register store: one clock of read latency, contents addr+0x80.
  logic       mem_init = 1'b1;
  logic [7:0] tb_mem [128];
  always @(posedge clock) begin
    if (mem_init) for (int i = 0; i < 128; i++) tb_mem[i] <= 8'(i + 128);
    else if (wr_en) tb_mem[wr_addr] <= wr_data;
    rd_data <= tb_mem[rd_addr];
  end

  int         checks = 0, failures = 0, dut_low = 0;
  logic [14:0] exp_q[$];
  logic [7:0]  model_mem [128];
  logic [6:0]  model_ptr;
  logic [7:0]  wq[$], rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic v);
    m_oe = ~v; tick(6); scl = 1'b1; tick(6); scl = 1'b0; tick(2);
  endtask

  task automatic recv_bit(output logic v);
    m_oe = 1'b0; tick(6); scl = 1'b1; tick(3); v = sda_bus; tick(3); scl = 1'b0; tick(2);
  endtask

  task automatic bus_start();
    m_oe = 1'b0; tick(4); scl = 1'b1; tick(6); m_oe = 1'b1; tick(6); scl = 1'b0; tick(2);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; tick(4); scl = 1'b1; tick(6); m_oe = 1'b0; tick(8);
  endtask

  task automatic wb(input logic [7:0] b, output logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(v);
    ack = (v == 1'b0);
  endtask

  task automatic rb(input logic send_ack, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin recv_bit(v); b[i] = v; end
    send_bit(~send_ack);
  endtask

  task automatic end_txn();
    bus_stop();
    chk("busy_idle", busy, 0);
    chk("rd_addr_model", rd_addr, model_ptr);
  endtask

  // Write burst of wq to pointer p; model expectations optional.
  task automatic m_write(input logic [6:0] p, input logic use_model);
    logic a;
    bus_start();
    wb(8'hD4, a); chk("addr_ack", a, 1); chk("busy_set", busy, 1);
    wb({1'b0, p}, a); chk("ptr_ack", a, 1);
    model_ptr = p;
    foreach (wq[i]) begin
      if (use_model) exp_q.push_back({model_ptr, wq[i]});
      model_mem[model_ptr] = wq[i];
      model_ptr = model_ptr + 7'd1;
      wb(wq[i], a); chk("data_ack", a, 1);
    end
    end_txn();
  endtask

  // Read n bytes, optionally setting the pointer first via repeated START.
  task automatic m_read(input logic set_ptr, input logic [6:0] p, input int n);
    logic a;
    logic [7:0] b;
    bus_start();
    if (set_ptr) begin
      wb(8'hD4, a); chk("rp_addr_ack", a, 1);
      wb({1'b0, p}, a); chk("rp_ptr_ack", a, 1);
      model_ptr = p;
      bus_start();
    end
    wb(8'hD5, a); chk("rd_addr_ack", a, 1); chk("rd_busy", busy, 1);
    rq.delete();
    for (int i = 0; i < n; i++) begin
      rb(i != n - 1, b);
      chk("rdata", b, model_mem[model_ptr]);
      rq.push_back(b);
      model_ptr = model_ptr + 7'd1;
    end
    tick(4);
    chk("busy_nack", busy, 0);
    chk("sda_released", sda_bus, 1);
    end_txn();
  endtask

  task automatic m_badaddr(input logic [7:0] ab);
    logic a;
    int low0;
    low0 = dut_low;
    bus_start();
    wb(ab, a); chk("bad_addr_nack", a, 0);
    wb(8'h00, a); chk("bad_data_nack", a, 0);
    chk("bad_busy", busy, 0);
    chk("sda_undriven", dut_low - low0, 0);
    end_txn();
  endtask

  initial begin
    logic a;
    logic [6:0] p;
    logic [6:0] ba;
    int n;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'(i + 128);
    model_ptr = 7'd0;

    fork
      // Strobe checker: every wr_en must match the next expected write.
      forever begin
        @(negedge clock);
        if (wr_en) begin
          if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            logic [14:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e[14:8]);
            chk("wr_data", wr_data, e[7:0]);
          end
        end
      end
      // Count clocks where SDA is low although the master is not pulling it.
      forever begin
        @(posedge clock);
        if (!m_oe && sda_bus === 1'b0) dut_low++;
      end
    join_none

    tick(3);
    mem_init = 1'b0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    chk("rst_state", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    tick(4);

    // Pointer then read: store returns addr+0x80.
    m_read(1'b1, 7'h05, 3);
    chk("rd_byte0", rq[0], 8'h85);
    chk("rd_byte1", rq[1], 8'h86);
    chk("rd_byte2", rq[2], 8'h87);
    chk("rd_ptr_end", rd_addr, 7'h08);

    // Write burst with literal expectations.
    wq = '{8'h11, 8'h22, 8'h33};
    exp_q.push_back({7'h00, 8'h11});
    exp_q.push_back({7'h01, 8'h22});
    exp_q.push_back({7'h02, 8'h33});
    m_write(7'h00, 1'b0);
    chk("wr_ptr_end", rd_addr, 7'h03);

    // Wrong address.
    m_badaddr(8'hD6);

    // Pointer wrap.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    exp_q.push_back({7'h7E, wq[0]});
    exp_q.push_back({7'h7F, wq[1]});
    exp_q.push_back({7'h00, wq[2]});
    exp_q.push_back({7'h01, wq[3]});
    m_write(7'h7E, 1'b0);
    chk("wrap_ptr_end", rd_addr, 7'h02);

    // Abort mid-byte, then a full write.
    bus_start();
    wb(8'hD4, a); chk("ab_addr_ack", a, 1);
    wb(8'h20, a); chk("ab_ptr_ack", a, 1);
    model_ptr = 7'h20;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop();
    chk("abort_idle", dut.state_q, ST_IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_ptr", rd_addr, 7'h20);
    wq = '{8'h5A};
    m_write(7'h21, 1'b1);

    // Reset while the target drives a 0 data bit.
    wq = '{8'h12};
    m_write(7'h10, 1'b1);
    bus_start();
    wb(8'hD4, a); wb(8'h10, a);
    bus_start();
    wb(8'hD5, a); chk("rr_addr_ack", a, 1);
    tick(4);
    chk("rr_drive_low", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    chk("rr_sda", sda_bus, 1);
    chk("rr_wr_en", wr_en, 0);
    chk("rr_wr_addr", wr_addr, 0);
    chk("rr_wr_data", wr_data, 0);
    chk("rr_rd_addr", rd_addr, 0);
    chk("rr_busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    model_ptr = 7'd0;
    m_oe = 1'b0; tick(4); scl = 1'b1; tick(8);
    wq = '{8'hC3};
    m_write(7'h33, 1'b1);

    // Randomized transactions against the model.
    for (int k = 0; k < 30; k++) begin
      p = 7'($urandom);
      n = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0: begin
          wq.delete();
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          m_write(p, 1'b1);
        end
        1: m_read(1'b1, p, n);
        2: m_read(1'b0, 7'd0, n);
        default: begin
          ba = 7'($urandom);
          if (ba == 7'h6A) ba = 7'h6B;
          m_badaddr({ba, 1'($urandom)});
        end
      endcase
    end

    tick(10);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
